sequenciador_estados: RTL and testbench

SEQUENCIADOR_ESTADOS -- requirements
Module: sequenciador_estados

---
 rtl/sequenciador_estados_pkg.sv | 52 +++++
 rtl/sequenciador_estados_gerador_imediato.sv | 33 +++
 rtl/sequenciador_estados.sv | 150 +++++++++++++++
 tb/tb_sequenciador_estados.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sequenciador_estados_pkg.sv
// ============================================================================
// Module : sequenciador_estados_pkg
// Desc   : state codes, opcodes and branch funct3 codes shared by the
//          sequencer and the control-signal generator (SEQUENCIADOR_TRAP_EN
//          adds the TRAP state).
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sequenciador_estados_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0000,
        ST_FETCH   = 4'b0001,
        ST_DECODE  = 4'b0011,
        ST_EXEC    = 4'b0010,
        ST_ALUWAIT = 4'b0100,
        ST_WB      = 4'b1111,
`ifdef SEQUENCIADOR_TRAP_EN
        ST_TRAP    = 4'b1110,
`endif
        ST_PCUPD   = 4'b0101
    } state_t;

    localparam logic [6:0] c_opc_lw     = 7'b0000011;
    localparam logic [6:0] c_opc_addi   = 7'b0010011;
    localparam logic [6:0] c_opc_sw     = 7'b0100011;
    localparam logic [6:0] c_opc_rtype  = 7'b0110011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;

    localparam logic [2:0] c_f3_beq = 3'b000;
    localparam logic [2:0] c_f3_bne = 3'b001;

    function automatic logic opcode_supported(input logic [6:0] opc);
        return (opc == c_opc_lw)    || (opc == c_opc_addi)  ||
               (opc == c_opc_sw)    || (opc == c_opc_rtype) ||
               (opc == c_opc_branch);
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z);
        logic t;
        t = 1'b0;
        if (f3 == c_f3_beq)
            t = z;
        else if (f3 == c_f3_bne)
            t = ~z;
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sequenciador_estados_gerador_imediato.sv
// ============================================================================
// Module : gerador_imediato
// Desc   : combinational sign-extended immediate (I/S/B, zero for R-type).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module gerador_imediato
    import sequenciador_estados_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    // Register and funct3 fields never feed the immediate.
    logic w_unused_bits;
    assign w_unused_bits = ^instr[19:12];

    always_comb begin
        imm = '0;
        case (instr[6:0])
            c_opc_lw,
            c_opc_addi:   imm = {{20{instr[31]}}, instr[31:20]};
            c_opc_sw:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            c_opc_branch: imm = {{19{instr[31]}}, instr[31], instr[7],
                                 instr[30:25], instr[11:8], 1'b0};
            default:      imm = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/sequenciador_estados.sv
// ============================================================================
// Module : sequenciador_estados
// Desc   : multi-cycle fetch/decode/execute sequencer; SEQUENCIADOR_TRAP_EN
//          enables the trap output and TRAP state for unknown opcodes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sequenciador_estados
    import sequenciador_estados_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        zero,
    output logic [3:0]  estado,
    output logic [2:0]  tipo,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic [31:0] pc,
`ifdef SEQUENCIADOR_TRAP_EN
    output logic        trap,
`endif
    output logic        halted
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        halted_q, halted_d;
    logic        taken_q, taken_d;
`ifdef SEQUENCIADOR_TRAP_EN
    logic        trap_q, trap_d;
`endif

    logic [6:0]  w_opcode;
    assign w_opcode = instr_q[6:0];

    gerador_imediato u_gerador_imediato (
        .instr (instr_q),
        .imm   (imm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            halted_q <= 1'b0;
            taken_q  <= 1'b0;
`ifdef SEQUENCIADOR_TRAP_EN
            trap_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            halted_q <= halted_d;
            taken_q  <= taken_d;
`ifdef SEQUENCIADOR_TRAP_EN
            trap_q   <= trap_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        halted_d = halted_q;
        taken_d  = taken_q;
`ifdef SEQUENCIADOR_TRAP_EN
        trap_d   = trap_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_FETCH;
                    halted_d = 1'b0;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // An all-zero word is the halt marker; pc stays on it.
                if (instr_q == 32'h0000_0000) begin
                    halted_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (opcode_supported(w_opcode)) begin
                    state_d = ST_EXEC;
                end else begin
`ifdef SEQUENCIADOR_TRAP_EN
                    trap_d   = 1'b1;
                    halted_d = 1'b1;
                    state_d  = ST_TRAP;
`else
                    taken_d  = 1'b0;
                    state_d  = ST_PCUPD;
`endif
                end
            end
            ST_EXEC:    state_d = ST_ALUWAIT;
            ST_ALUWAIT: state_d = ST_WB;
            ST_WB: begin
                taken_d = (w_opcode == c_opc_branch) &&
                          branch_taken(instr_q[14:12], zero);
                state_d = ST_PCUPD;
            end
            ST_PCUPD: begin
                pc_d    = taken_q ? (pc_q + imm) : (pc_q + 32'd4);
                state_d = ST_FETCH;
            end
`ifdef SEQUENCIADOR_TRAP_EN
            ST_TRAP:    state_d = ST_TRAP;
`endif
            default:    state_d = ST_IDLE;
        endcase
    end

    assign estado    = state_q;
    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign halted    = halted_q;
`ifdef SEQUENCIADOR_TRAP_EN
    assign trap      = trap_q;
`endif

    assign tipo   = instr_q[6:4];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign rd     = instr_q[11:7];

endmodule

`default_nettype wire

// File: tb/tb_sequenciador_estados.sv
// ============================================================================
// Module : tb_sequenciador_estados
// Desc   : directed vector table plus corner sequences for the sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sequenciador_estados;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = '0;
    logic        zero = 1'b0;
    logic [3:0]  estado;
    logic [2:0]  tipo, funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, pc;
    logic        halted;
`ifdef SEQUENCIADOR_TRAP_EN
    logic        trap;
`endif

    sequenciador_estados dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .zero      (zero),
        .estado    (estado),
        .tipo      (tipo),
        .funct3    (funct3),
        .funct7    (funct7),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .imm       (imm),
        .pc        (pc),
`ifdef SEQUENCIADOR_TRAP_EN
        .trap      (trap),
`endif
        .halted    (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        int          dly;
        logic        z;
        logic [31:0] pc;
        logic [2:0]  tipo;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        halted;
        logic [23:0] seq;
    } vec_t;

    vec_t vecs [12];

    int          total = 0;
    int          bad   = 0;
    logic [23:0] seq;
    int          req_wait;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from IDLE or FETCH; garbage ack and start are
    // driven while the sequencer is outside FETCH/IDLE and must be ignored.
    task automatic run_instr(input logic [31:0] w, input int dly, input logic z);
        logic [31:0] addr0;
        int          guard;
        zero = z;
        if (estado == 4'b0000) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
        addr0    = imem_addr;
        req_wait = 0;
        for (int i = 0; i < dly; i++) begin
            if (imem_req && imem_addr == addr0) req_wait++;
            step();
        end
        imem_ack  = 1'b1;
        imem_data = w;
        step();
        imem_data = 32'hDEAD_BEEF;
        seq   = '0;
        guard = 0;
        forever begin
            seq = {seq[19:0], estado};
            if (estado == 4'b0001 || estado == 4'b0000 || estado == 4'b1110) break;
            if (guard >= 8) begin
                check("timeout", 32'(estado), 32'hFFFF_FFFF);
                break;
            end
            start = 1'b1;
            step();
            guard++;
        end
        imem_ack = 1'b0;
        start    = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{32'h00500093, 3, 1'b0, 32'd4,  3'b001, 3'd0, 7'h00, 5'd0, 5'd5,  5'd1,  32'd5,        1'b0, 24'h324F51};
        vecs[1]  = '{32'h0020A423, 0, 1'b0, 32'd8,  3'b010, 3'd2, 7'h00, 5'd1, 5'd2,  5'd8,  32'd8,        1'b0, 24'h324F51};
        vecs[2]  = '{32'hFE000CE3, 0, 1'b1, 32'd0,  3'b110, 3'd0, 7'h7F, 5'd0, 5'd0,  5'd25, 32'hFFFFFFF8, 1'b0, 24'h324F51};
        vecs[3]  = '{32'h00500093, 1, 1'b1, 32'd4,  3'b001, 3'd0, 7'h00, 5'd0, 5'd5,  5'd1,  32'd5,        1'b0, 24'h324F51};
        vecs[4]  = '{32'h00500093, 0, 1'b0, 32'd8,  3'b001, 3'd0, 7'h00, 5'd0, 5'd5,  5'd1,  32'd5,        1'b0, 24'h324F51};
        vecs[5]  = '{32'hFE000CE3, 0, 1'b0, 32'd12, 3'b110, 3'd0, 7'h7F, 5'd0, 5'd0,  5'd25, 32'hFFFFFFF8, 1'b0, 24'h324F51};
        vecs[6]  = '{32'h00001863, 2, 1'b0, 32'd28, 3'b110, 3'd1, 7'h00, 5'd0, 5'd0,  5'd16, 32'd16,       1'b0, 24'h324F51};
        vecs[7]  = '{32'h00001863, 0, 1'b1, 32'd32, 3'b110, 3'd1, 7'h00, 5'd0, 5'd0,  5'd16, 32'd16,       1'b0, 24'h324F51};
        vecs[8]  = '{32'h002081B3, 0, 1'b1, 32'd36, 3'b011, 3'd0, 7'h00, 5'd1, 5'd2,  5'd3,  32'd0,        1'b0, 24'h324F51};
        vecs[9]  = '{32'hFFC12283, 0, 1'b0, 32'd40, 3'b000, 3'd2, 7'h7F, 5'd2, 5'd28, 5'd5,  32'hFFFFFFFC, 1'b0, 24'h324F51};
        vecs[10] = '{32'hFE004CE3, 0, 1'b1, 32'd44, 3'b110, 3'd4, 7'h7F, 5'd0, 5'd0,  5'd25, 32'hFFFFFFF8, 1'b0, 24'h324F51};
        vecs[11] = '{32'h00000000, 0, 1'b0, 32'd44, 3'b000, 3'd0, 7'h00, 5'd0, 5'd0,  5'd0,  32'd0,        1'b1, 24'h000030};

        repeat (2) @(posedge clk);
        #1;
        check("rst_estado", 32'(estado),   32'h0);
        check("rst_req",    32'(imem_req), 32'h0);
        check("rst_pc",     pc,            32'h0);
        check("rst_halted", 32'(halted),   32'h0);
        check("rst_imm",    imm,           32'h0);
        check("rst_rd",     32'(rd),       32'h0);
        rst_n = 1'b1;
        step();
        check("idle_hold", 32'(estado), 32'h0);

        for (int i = 0; i < 12; i++) begin
            run_instr(vecs[i].word, vecs[i].dly, vecs[i].z);
            check($sformatf("v%0d_reqwait", i), 32'(req_wait),     32'(vecs[i].dly));
            check($sformatf("v%0d_seq", i),     32'(seq),          32'(vecs[i].seq));
            check($sformatf("v%0d_pc", i),      pc,                vecs[i].pc);
            check($sformatf("v%0d_tipo", i),    32'(tipo),         32'(vecs[i].tipo));
            check($sformatf("v%0d_funct3", i),  32'(funct3),       32'(vecs[i].f3));
            check($sformatf("v%0d_funct7", i),  32'(funct7),       32'(vecs[i].f7));
            check($sformatf("v%0d_rs1", i),     32'(rs1),          32'(vecs[i].rs1));
            check($sformatf("v%0d_rs2", i),     32'(rs2),          32'(vecs[i].rs2));
            check($sformatf("v%0d_rd", i),      32'(rd),           32'(vecs[i].rd));
            check($sformatf("v%0d_imm", i),     imm,               vecs[i].imm);
            check($sformatf("v%0d_halted", i),  32'(halted),       32'(vecs[i].halted));
        end

        // Restart from halt: start clears halted.
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_estado", 32'(estado), 32'h1);
        check("restart_halted", 32'(halted), 32'h0);
        check("restart_addr",   imem_addr,   32'd44);

        run_instr(32'h0000007F, 0, 1'b0);
        check("unk_tipo", 32'(tipo), 32'h7);
`ifdef SEQUENCIADOR_TRAP_EN
        check("unk_seq",    32'(seq),    32'h00003E);
        check("unk_trap",   32'(trap),   32'h1);
        check("unk_halted", 32'(halted), 32'h1);
        check("unk_pc",     pc,          32'd44);
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        check("trap_sticky", 32'(estado), 32'hE);
        check("trap_noreq",  32'(imem_req), 32'h0);
`else
        check("unk_seq",    32'(seq),    32'h000351);
        check("unk_pc",     pc,          32'd48);
        check("unk_halted", 32'(halted), 32'h0);
`endif

        // Asynchronous reset in the middle of a fetch.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        run_instr(32'h00500093, 0, 1'b0);
        check("pre_rst_req", 32'(imem_req), 32'h1);
        check("pre_rst_pc",  pc,            32'd4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_req",    32'(imem_req), 32'h0);
        check("arst_estado", 32'(estado),   32'h0);
        check("arst_pc",     pc,            32'h0);
        check("arst_rd",     32'(rd),       32'h0);
        check("arst_imm",    imm,           32'h0);
        check("arst_halted", 32'(halted),   32'h0);
`ifdef SEQUENCIADOR_TRAP_EN
        check("arst_trap",   32'(trap),     32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
